// File: rtl/pcm_i2s_tx.sv
// pcm_i2s_tx: mono PCM sample FIFO to I2S serialiser with its own bit clock and underrun flag
module pcm_i2s_tx #(
  parameter int dat_width = 6,
  parameter int slot_width = 32,
  parameter int clk_div = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [dat_width-1:0] fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  output logic                 bclk,
  output logic                 ws,
  output logic                 sd,
  output logic                 underrun
);
  localparam int dw = clk_div > 1 ? $clog2(clk_div) : 1;
  localparam int bw = $clog2(2 * slot_width);
  localparam logic [1:0] idle = 2'd0, fetch = 2'd1, run = 2'd2;
  logic [1:0] state;
  logic [dw-1:0] div_cnt;
  logic [bw-1:0] bit_cnt;
  logic [dat_width-1:0] hold, nxt, sh;
  logic tick, fall, nws;
  int k, j;
  // position of the bit that starts at the next bclk falling edge, and its ws/sd values
  always_comb begin
    tick = int'(div_cnt) == clk_div - 1;
    fall = tick && bclk;
    k = int'(bit_cnt) == 2 * slot_width - 1 ? 0 : int'(bit_cnt) + 1;
    j = k >= slot_width ? k - slot_width : k;
    sh = (k == 0 ? nxt : hold) << j;
    nws = k >= slot_width - 1 && k <= 2 * slot_width - 2;
  end
  // fetch/serialise state machine; the sample for the next frame is read during the last bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= idle;
      div_cnt <= '0;
      bit_cnt <= '0;
      hold <= '0;
      nxt <= '0;
      bclk <= 1'b0;
      ws <= 1'b0;
      sd <= 1'b0;
      fifo_rd <= 1'b0;
      underrun <= 1'b0;
    end else begin
      fifo_rd <= 1'b0;
      underrun <= 1'b0;
      if (!en) begin
        state <= idle;
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk <= 1'b0;
        ws <= 1'b0;
        sd <= 1'b0;
      end else if (state == idle) begin
        if (!fifo_empty) begin
          fifo_rd <= 1'b1;
          state <= fetch;
        end
      end else if (state == fetch) begin
        hold <= fifo_data;
        bit_cnt <= '0;
        div_cnt <= '0;
        bclk <= 1'b0;
        ws <= 1'b0;
        sd <= fifo_data[dat_width-1];
        state <= run;
      end else begin
        if (fifo_rd) nxt <= fifo_data;
        div_cnt <= tick ? '0 : div_cnt + dw'(1);
        if (tick) bclk <= ~bclk;
        if (fall) begin
          bit_cnt <= bw'(k);
          ws <= nws;
          sd <= sh[dat_width-1];
          if (k == 0) hold <= nxt;
          if (k == 2 * slot_width - 1) begin
            if (fifo_empty) begin
              nxt <= '0;
              underrun <= 1'b1;
            end else fifo_rd <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pcm_i2s_tx.sv
// tb_pcm_i2s_tx: randomized I2S transmitter bench with a DAC-side frame model
module tb_pcm_i2s_tx;
  localparam int W = 6, S = 8, CD = 2;
  logic clk = 0, reset = 0, en = 0, fifo_empty = 1, en1 = 0;
  logic [W-1:0] fifo_data = '0, cur = '0;
  logic [5:0] d1 = '0, cur1 = '0;
  logic fifo_rd, bclk, ws, sd, underrun;
  logic fifo_rd1, bclk1, ws1, sd1, underrun1;
  logic pb = 0, pend = 0, pb1 = 0, pend1 = 0;
  int checks = 0, failures = 0;
  int b = 0, cyc = 0, last = 0, ur_cnt = 0, ur_exp = 0, rd_cnt = 0, pop_exp = 0;
  int b1 = 0, rd1 = 0, cyc1 = 0, last1 = 0;
  logic [W-1:0] fq[$], mq[$];
  logic [5:0] q1[$];

  pcm_i2s_tx #(.dat_width(W), .slot_width(S), .clk_div(CD)) dut (
    .clk(clk), .reset(reset), .en(en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .bclk(bclk), .ws(ws), .sd(sd), .underrun(underrun)
  );
  pcm_i2s_tx #(.dat_width(6), .slot_width(6), .clk_div(1)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .fifo_data(d1), .fifo_empty(1'b0),
    .fifo_rd(fifo_rd1), .bclk(bclk1), .ws(ws1), .sd(sd1), .underrun(underrun1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    fq.push_back(v);
    mq.push_back(v);
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    while (b < n && t < 5000) begin
      @(posedge clk);
      #2 t++;
    end
    if (b < n) chk("wait_bits", b, n);
  endtask

  task automatic end_counts();
    chk("underruns", ur_cnt, ur_exp);
    chk("pops", rd_cnt, pop_exp);
    ur_cnt = 0;
    ur_exp = 0;
    rd_cnt = 0;
    pop_exp = 0;
  endtask

  task automatic finish_run(input int n);
    wait_bits(n);
    en = 0;
    @(posedge clk);
    #1 chk("abort_outs", int'({bclk, ws, sd}), 0);
    repeat (3) @(posedge clk);
    #2 end_counts();
  endtask

  // DAC-side receiver: each frame carries the next queued sample in both slots, or silence if none
  always @(negedge clk) begin
    logic [W-1:0] sh;
    int k;
    cyc++;
    if (!reset || !en) b = 0;
    else if (bclk && !pb) begin
      k = b % (2 * S);
      if (k == 0) begin
        if (mq.size() > 0) begin
          cur = mq.pop_front();
          pop_exp++;
        end else begin
          cur = '0;
          ur_exp++;
        end
      end
      if (b > 0) chk("bclk_period", cyc - last, 2 * CD);
      last = cyc;
      sh = cur << (k % S);
      chk("ws", int'(ws), int'(((k + 1) % (2 * S)) >= S));
      chk("sd", int'(sd), int'(sh[W-1]));
      b++;
    end
    if (underrun) ur_cnt++;
    if (fifo_rd) begin
      rd_cnt++;
      chk("rd_when_empty", int'(fifo_empty), 0);
    end
    pb = bclk;
    if (pend && fq.size() > 0) void'(fq.pop_front());
    pend = fifo_rd;
    fifo_empty = fq.size() == 0;
    fifo_data = fq.size() > 0 ? fq[0] : '0;
  end

  // receiver and always-full source for the fast, unpadded instance
  always @(negedge clk) begin
    logic [5:0] sh1;
    int k1;
    cyc1++;
    if (!en1) begin
      b1 = 0;
      rd1 = 0;
      q1.delete();
    end else if (bclk1 && !pb1) begin
      k1 = b1 % 12;
      if (k1 == 0) begin
        chk("u1_rd_per_frame", rd1, b1 / 12 + 1);
        if (q1.size() > 0) cur1 = q1.pop_front();
        else cur1 = '0;
      end
      if (b1 > 0) chk("u1_bclk_period", cyc1 - last1, 2);
      last1 = cyc1;
      sh1 = cur1 << (k1 % 6);
      chk("u1_ws", int'(ws1), int'(((k1 + 1) % 12) >= 6));
      chk("u1_sd", int'(sd1), int'(sh1[5]));
      b1++;
    end
    pb1 = bclk1;
    if (pend1) d1 = 6'($urandom);
    pend1 = fifo_rd1;
    if (fifo_rd1 && en1) begin
      rd1++;
      q1.push_back(d1);
    end
  end

  initial begin
    int nf;
    en = 1;
    repeat (3) begin
      @(posedge clk);
      #1 chk("rst_outs", int'({fifo_rd, bclk, ws, sd, underrun}), 0);
    end
    @(posedge clk);
    #2 reset = 1;
    repeat (8) begin
      @(posedge clk);
      #1 chk("idle_empty", int'({fifo_rd, bclk, ws, sd, underrun}), 0);
    end
    @(posedge clk);
    #2 en = 0;
    push(6'b101101);
    push(6'b010011);
    @(posedge clk);
    #2 en = 1;
    @(posedge clk);
    #1 chk("lat_rd", int'(fifo_rd), 1);
    @(posedge clk);
    #1 chk("lat_msb", int'({bclk, ws, sd}), 1);
    wait_bits(3 * 2 * S + 9);
    push(6'b111000);
    wait_bits(5 * 2 * S + 6);
    chk("ur_directed", ur_cnt, 3);
    finish_run(5 * 2 * S + 6);
    repeat (6) begin
      repeat ($urandom_range(1, 3)) push(W'($urandom));
      @(posedge clk);
      #2 en = 1;
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        wait_bits(f * 2 * S + 9);
        if ($urandom_range(0, 1) == 1) push(W'($urandom));
      end
      finish_run(nf * 2 * S + 6);
    end
    push(W'($urandom));
    push(W'($urandom));
    @(posedge clk);
    #2 en = 1;
    wait_bits(4);
    #1 reset = 0;
    #1 chk("async_rst", int'({fifo_rd, bclk, ws, sd, underrun}), 0);
    end_counts();
    repeat (3) begin
      @(posedge clk);
      #1 chk("rst_no_rd", int'(fifo_rd), 0);
    end
    @(posedge clk);
    #2 reset = 1;
    finish_run(2 * S + 6);
    @(posedge clk);
    #2 en1 = 1;
    repeat (150) @(posedge clk);
    #2 chk("u1_bits", int'(b1 >= 60), 1);
    en1 = 0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
